// File: rtl/prog_down_timer.sv
// prog_down_timer: programmable down-counting timer with optional auto-reload.
// The host loads a reload value, starts the countdown, and receives a single
// registered tc_pulse when the count reaches zero. With auto_reload set the
// count is refilled from the reload register and the timer keeps running,
// giving a periodic tick with a period of rld cycles.
module prog_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic             out_enable,
    output logic [WIDTH-1:0] count,
    output logic             tc_pulse,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_pulse_q, tc_pulse_d;

    logic             cnt_is_zero;
    logic             cnt_is_one;
    logic             rld_is_zero;
    logic [WIDTH-1:0] cnt_minus_one;

    // Decode the count and reload values once so the FSM reads cleanly.
    always_comb begin
        cnt_is_zero   = (cnt_q == '0);
        cnt_is_one    = (cnt_q == WIDTH'(1));
        rld_is_zero   = (rld_q == '0);
        cnt_minus_one = cnt_q - WIDTH'(1);
    end

    // Next-state, next-count and pulse logic; load outranks every state action,
    // and within a state stop outranks start, which outranks the countdown.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rld_d      = rld_q;
        tc_pulse_d = 1'b0;

        if (load) begin
            // A load always parks the timer, so any terminal count that
            // would have fired on this edge is dropped.
            rld_d   = load_value;
            cnt_d   = load_value;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Arming with a zero count would expire immediately
                    // without a meaningful period, so it is ignored.
                    if (!stop && start && !cnt_is_zero) begin
                        state_d = RUN;
                    end
                end

                RUN: begin
                    if (stop) begin
                        // Pause: the count is held for a later resume.
                        state_d = IDLE;
                    end else if (cnt_is_one) begin
                        tc_pulse_d = 1'b1;
                        if (auto_reload) begin
                            cnt_d = rld_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = EXPIRED;
                        end
                    end else if (cnt_is_zero) begin
                        // Unreachable in normal use; never wrap below zero.
                        state_d = EXPIRED;
                    end else begin
                        cnt_d = cnt_minus_one;
                    end
                end

                EXPIRED: begin
                    cnt_d = '0;
                    if (stop) begin
                        state_d = IDLE;
                    end else if (start && !rld_is_zero) begin
                        cnt_d   = rld_q;
                        state_d = RUN;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, count, reload and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rld_q      <= '0;
            tc_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rld_q      <= rld_d;
            tc_pulse_q <= tc_pulse_d;
        end
    end

    // Output decode; only the count value is gated by out_enable.
    always_comb begin
        count    = out_enable ? cnt_q : '0;
        tc_pulse = tc_pulse_q;
        busy     = (state_q == RUN);
        done     = (state_q == EXPIRED);
    end

endmodule

// File: tb/tb_prog_down_timer.sv
// tb_prog_down_timer: table-driven checks plus hand-written corner sequences.
module tb_prog_down_timer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic             out_enable;
    logic [WIDTH-1:0] count;
    logic             tc_pulse;
    logic             busy;
    logic             done;

    int checkCount;
    int errorCount;

    typedef struct {
        logic             rst;
        logic             load;
        logic [WIDTH-1:0] loadValue;
        logic             start;
        logic             stop;
        logic             autoReload;
        logic             outEnable;
        logic [WIDTH-1:0] expCount;
        logic             expTc;
        logic             expBusy;
        logic             expDone;
    } vector_t;

    vector_t vectors[$];

    prog_down_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .out_enable (out_enable),
        .count      (count),
        .tc_pulse   (tc_pulse),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs at the falling edge, then sample 1 unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic ld, input logic [WIDTH-1:0] lv,
                                 input logic st, input logic sp, input logic ar,
                                 input logic oe);
        @(negedge clk);
        rst         = r;
        load        = ld;
        load_value  = lv;
        start       = st;
        stop        = sp;
        auto_reload = ar;
        out_enable  = oe;
        @(posedge clk);
        #1;
    endtask

    // Compare all four observable outputs against the expected values.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] expCount,
                               input logic expTc, input logic expBusy, input logic expDone);
        checkCount++;
        if (count !== expCount) begin
            errorCount++;
            $display("[TB] FAIL %s count got %0h expected %0h", name, count, expCount);
        end
        checkCount++;
        if (tc_pulse !== expTc) begin
            errorCount++;
            $display("[TB] FAIL %s tc_pulse got %0b expected %0b", name, tc_pulse, expTc);
        end
        checkCount++;
        if (busy !== expBusy) begin
            errorCount++;
            $display("[TB] FAIL %s busy got %0b expected %0b", name, busy, expBusy);
        end
        checkCount++;
        if (done !== expDone) begin
            errorCount++;
            $display("[TB] FAIL %s done got %0b expected %0b", name, done, expDone);
        end
    endtask

    task automatic addVec(input logic r, input logic ld, input logic [WIDTH-1:0] lv,
                          input logic st, input logic sp, input logic ar, input logic oe,
                          input logic [WIDTH-1:0] ec, input logic et, input logic eb,
                          input logic ed);
        vector_t v;
        v.rst = r; v.load = ld; v.loadValue = lv; v.start = st; v.stop = sp;
        v.autoReload = ar; v.outEnable = oe;
        v.expCount = ec; v.expTc = et; v.expBusy = eb; v.expDone = ed;
        vectors.push_back(v);
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        rst         = 1'b1;
        load        = 1'b0;
        load_value  = '0;
        start       = 1'b0;
        stop        = 1'b0;
        auto_reload = 1'b0;
        out_enable  = 1'b1;

        // Vector table: rst ld lv start stop ar oe | count tc busy done
        // Reset, then a one-shot countdown of 3.
        addVec(1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0);
        addVec(1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0);
        addVec(0, 1, 8'h03, 0, 0, 0, 1, 8'h03, 0, 0, 0);
        addVec(0, 0, 8'h00, 1, 0, 0, 1, 8'h03, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 0, 0, 1, 8'h02, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 0, 0, 1, 8'h01, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 0, 1);
        addVec(0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 1);
        addVec(0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 1);
        // stop leaves EXPIRED for IDLE.
        addVec(0, 0, 8'h00, 0, 1, 0, 1, 8'h00, 0, 0, 0);
        // Auto-reload with period 4.
        addVec(0, 1, 8'h04, 0, 0, 1, 1, 8'h04, 0, 0, 0);
        addVec(0, 0, 8'h00, 1, 0, 1, 1, 8'h04, 0, 1, 0);
        for (int p = 0; p < 3; p++) begin
            addVec(0, 0, 8'h00, 0, 0, 1, 1, 8'h03, 0, 1, 0);
            addVec(0, 0, 8'h00, 0, 0, 1, 1, 8'h02, 0, 1, 0);
            addVec(0, 0, 8'h00, 0, 0, 1, 1, 8'h01, 0, 1, 0);
            addVec(0, 0, 8'h00, 0, 0, 1, 1, 8'h04, 1, 1, 0);
        end
        addVec(0, 0, 8'h00, 0, 0, 1, 1, 8'h03, 0, 1, 0);
        // Output gating while running; busy and tc_pulse stay live.
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 1, 0);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 0);

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].rst, vectors[i].load, vectors[i].loadValue,
                          vectors[i].start, vectors[i].stop, vectors[i].autoReload,
                          vectors[i].outEnable);
            checkOutput($sformatf("vec%0d", i), vectors[i].expCount, vectors[i].expTc,
                        vectors[i].expBusy, vectors[i].expDone);
        end

        // The hidden count is 3 here; enabling the output shows it without an edge.
        @(negedge clk);
        out_enable = 1'b1;
        #1;
        checkOutput("gate_live", 8'h03, 0, 1, 0);

        // Pause and resume: load 10, three decrements, stop at 7.
        applyStimulus(0, 1, 8'h0A, 0, 0, 0, 1);
        checkOutput("pause_load", 8'h0A, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
        checkOutput("pause_start", 8'h0A, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
            checkOutput($sformatf("pause_dec%0d", i), 8'(10 - i), 0, 1, 0);
        end
        applyStimulus(0, 0, 8'h00, 0, 1, 0, 1);
        checkOutput("pause_stop", 8'h07, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
            checkOutput($sformatf("pause_hold%0d", i), 8'h07, 0, 0, 0);
        end
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
        checkOutput("resume_start", 8'h07, 0, 1, 0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
            checkOutput($sformatf("resume_dec%0d", i), 8'(7 - i), (i == 7),
                        (i != 7), (i == 7));
        end

        // Zero load cannot be started.
        applyStimulus(0, 1, 8'h00, 0, 0, 0, 1);
        checkOutput("zero_load", 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
        checkOutput("zero_start", 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("zero_after", 8'h00, 0, 0, 0);

        // Full-range one-shot of 255, then re-arm from EXPIRED.
        applyStimulus(0, 1, 8'hFF, 0, 0, 0, 1);
        checkOutput("ff_load", 8'hFF, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
        checkOutput("ff_start", 8'hFF, 0, 1, 0);
        for (int i = 1; i <= 255; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
            if (i >= 253) begin
                checkOutput($sformatf("ff_dec%0d", i), 8'(255 - i), (i == 255),
                            (i != 255), (i == 255));
            end
        end
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("ff_nowrap", 8'h00, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
        checkOutput("ff_rearm", 8'hFF, 0, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("ff_rearm_dec", 8'hFE, 0, 1, 0);

        // load together with start mid-RUN: load wins and parks the timer.
        applyStimulus(0, 1, 8'h05, 1, 0, 0, 1);
        checkOutput("load_start", 8'h05, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
        checkOutput("load_restart", 8'h05, 0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
            checkOutput($sformatf("pre_rst_dec%0d", i), 8'(5 - i), 0, 1, 0);
        end
        // Reset at cnt=1 aborts with no terminal-count pulse.
        applyStimulus(1, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("rst_abort", 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("rst_after", 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
        checkOutput("rst_start_ignored", 8'h00, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
